elev_ctrl_scan: RTL and testbench
=================================

Name: elev_ctrl_scan

Overview:
Parametrised successor to the four-floor elevator controller. It supports NUM_FLOORS floors and latches multiple outstanding floor requests. Requests are served in SCAN order: it keeps its direction while requests remain ahead, then reverses. A door dwell timer, a door-hold input and a per-floor travel timer replace the fixed one-cycle open/close stepping.

Parameters:
NUM_FLOORS, 4, number of floors (>=2); floor 0 is the bottom.
DOOR_CYCLES, 4, cycles the door stays open after the last (re)trigger (>=1).
TRAVEL_CYCLES, 2, cycles spent moving between adjacent floors (>=1).
FLOOR_W, $clog2(NUM_FLOORS), derived localparam; floor index width.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
floor_btn  in  NUM_FLOORS  one bit per floor; any-cycle level/pulse request, OR-ed into the pending set
door_hold  in  1  while high in OPEN, reloads the dwell timer
floor_sel  out  FLOOR_W  current floor index
door  out  1  1 = door open
moving  out  1  1 while in MOVE
dir_up  out  1  current/last travel direction, 1 = up
pending  out  NUM_FLOORS  registered outstanding requests

Behaviour:
- One clock: clk. Reset rst is asynchronous, active-high.
- Reset values (asynchronous, including mid-travel):
  - state OPEN, floor_sel 0, door 1, moving 0, dir_up 1.
  - pending all 0; timer loaded with DOOR_CYCLES-1.
- Pending register:
  - pending_next = (pending | floor_btn) & ~clear_mask.
  - clear_mask = onehot(floor_sel) whenever the next state is OPEN or the current state is OPEN.
  - A request for the current floor while the door is open is never stored. Instead it reloads the dwell timer.
- Lookahead terms: above = |pending[NUM_FLOORS-1:floor_sel+1]; below = |pending[floor_sel-1:0]. Floor 0 has no below; the top floor has no above.
- Direction pick (on leaving OPEN or IDLE):
  - If dir_up: go up when above, else down when below.
  - If !dir_up: go down when below, else up when above.
  - dir_up is updated on that edge.
- States:
  - OPEN: door=1.
    - Timer decrements each cycle.
    - Timer reloads to DOOR_CYCLES-1 when door_hold is high or floor_btn[floor_sel] is high.
    - When the timer is 0 and not reloading: go to MOVE (load TRAVEL_CYCLES-1) if above|below, else IDLE.
    - Door is therefore open exactly DOOR_CYCLES cycles absent re-triggers.
  - IDLE: door=0, moving=0.
    - If pending[floor_sel] or floor_btn[floor_sel]: go to OPEN (timer DOOR_CYCLES-1).
    - Else if above|below: pick direction, go to MOVE.
    - Else stay.
  - MOVE: door=0, moving=1.
    - Timer decrements; on the timer==0 edge, floor_sel steps ±1 per dir_up.
    - On that same edge, with the target f = new floor:
      - If pending[f] | floor_btn[f]: go to OPEN, clear f.
      - Else if requests remain ahead in dir_up: reload travel timer, stay MOVE.
      - Else: go to IDLE.
    - floor_btn pulses during MOVE are captured and honoured on arrival at that floor.
- Safety: floor_sel never under- or overflows; stepping past 0 or NUM_FLOORS-1 is illegal (bench assertion). door and moving are never both 1.
- Latency example (TRAVEL_CYCLES=2, from IDLE at floor 0):
  - btn[2] sampled at edge E; pending[2] visible after E.
  - Edge E+1 enters MOVE; floor_sel=1 after E+2; floor_sel=2 and door=1 after E+4.
- Simultaneous requests above and below in IDLE with dir_up=1: up first.
- Timer width: $clog2(max(DOOR_CYCLES,TRAVEL_CYCLES)+1); shared by OPEN and MOVE.

Decomposition:
- Package elev_pkg:
  - state_t enum {IDLE, OPEN, MOVE}.
  - Helper function for the above/below reduction, parametrised by vector and index.
- Sub-module elev_req_reg: holds the pending register and clear logic, and outputs above/below/here for a given floor index.
- The top level holds the FSM, the timer and floor_sel.

Test Plan:
1. Reset then idle: rst pulse, no buttons → floor_sel=0, door=1 for 4 cycles, then door=0, state IDLE, pending=0.
2. Single trip: IDLE at 0, btn[3] one cycle → moving=1; floor_sel steps 1,2,3 every 2 cycles; door=1 at floor 3 for 4 cycles; pending[3]=0.
3. SCAN order: at floor 1 going up, pending {0,3} then btn[2] during MOVE → stops at 2, then 3, then reverses to 0; dir_up toggles to 0 only after floor 3.
4. Door hold / re-trigger: door_hold high 10 cycles in OPEN → door stays 1 for 10+4 cycles; btn[floor_sel] in OPEN → timer reload, pending bit never set.
5. Async reset mid-MOVE between floors 1→2: rst asserted off-edge → outputs immediately floor_sel=0, door=1, moving=0, pending=0.
6. Parameter sweep: NUM_FLOORS=8, DOOR_CYCLES=1, TRAVEL_CYCLES=1 → 0→7 trip takes 7 cycles after MOVE entry; no out-of-range floor_sel assertion fires.

Source files
------------

// File: rtl/elev_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : elev_pkg
//  Purpose  : Shared state type and request-lookahead helper for elev_ctrl_scan.
//  Revision : 1.0
// ============================================================================
package elev_pkg;

    localparam int MAX_FLOORS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        MOVE = 2'd2
    } state_t;

    // OR of every bit strictly above (up=1) or strictly below (up=0) idx.
    function automatic logic any_beyond(input logic [MAX_FLOORS-1:0] vec,
                                        input int                    idx,
                                        input logic                  up);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if ((up && (i > idx)) || (!up && (i < idx))) begin
                r = r | vec[i];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elev_req_reg.sv
`default_nettype none
// ============================================================================
//  Module   : elev_req_reg
//  Purpose  : Pending floor-request register with clear mask and lookahead.
//  Revision : 1.0
// ============================================================================
module elev_req_reg #(
    parameter int NUM_FLOORS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_FLOORS-1:0]         floor_btn_i,
    input  logic                          clr_en_i,
    input  logic [$clog2(NUM_FLOORS)-1:0] clr_idx_i,
    input  logic [$clog2(NUM_FLOORS)-1:0] qry_idx_i,
    output logic [NUM_FLOORS-1:0]         pending_o,
    output logic                          above_o,
    output logic                          below_o,
    output logic                          here_o
);
    import elev_pkg::*;

    logic [NUM_FLOORS-1:0] pending_q;
    logic [NUM_FLOORS-1:0] pending_d;
    logic [NUM_FLOORS-1:0] clr_mask;

    // Clearing wins over a same-cycle press, so a request for the floor whose
    // door is open never gets stored.
    always_comb begin
        clr_mask = '0;
        if (clr_en_i) begin
            clr_mask[clr_idx_i] = 1'b1;
        end
        pending_d = (pending_q | floor_btn_i) & ~clr_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
    assign above_o   = any_beyond(MAX_FLOORS'(pending_q), int'(qry_idx_i), 1'b1);
    assign below_o   = any_beyond(MAX_FLOORS'(pending_q), int'(qry_idx_i), 1'b0);
    assign here_o    = pending_q[qry_idx_i];

endmodule
`default_nettype wire

// File: rtl/elev_ctrl_scan.sv
`default_nettype none
// ============================================================================
//  Module   : elev_ctrl_scan
//  Purpose  : SCAN-order elevator controller with door dwell and travel timers.
//  Revision : 1.0
// ============================================================================
module elev_ctrl_scan #(
    parameter int NUM_FLOORS    = 4,
    parameter int DOOR_CYCLES   = 4,
    parameter int TRAVEL_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_FLOORS-1:0]         floor_btn,
    input  logic                          door_hold,
    output logic [$clog2(NUM_FLOORS)-1:0] floor_sel,
    output logic                          door,
    output logic                          moving,
    output logic                          dir_up,
    output logic [NUM_FLOORS-1:0]         pending
);
    import elev_pkg::*;

    localparam int FLOOR_W = $clog2(NUM_FLOORS);
    localparam int TIMER_W = $clog2(((DOOR_CYCLES > TRAVEL_CYCLES) ?
                                     DOOR_CYCLES : TRAVEL_CYCLES) + 1);

    localparam logic [TIMER_W-1:0] c_door_reload   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_travel_reload = TIMER_W'(TRAVEL_CYCLES - 1);

    state_t               state_q, state_d;
    logic [FLOOR_W-1:0]   floor_q, floor_d;
    logic                 dir_q,   dir_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;

    logic                 above, below, here;
    logic                 pick_up;
    logic [FLOOR_W-1:0]   step_floor;
    logic                 step_hit;
    logic                 step_ahead;
    logic                 clr_en;

    elev_req_reg #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_req (
        .clk         (clk),
        .rst         (rst),
        .floor_btn_i (floor_btn),
        .clr_en_i    (clr_en),
        .clr_idx_i   (floor_d),
        .qry_idx_i   (floor_q),
        .pending_o   (pending),
        .above_o     (above),
        .below_o     (below),
        .here_o      (here)
    );

    // Keep heading while work remains ahead, otherwise turn around.
    assign pick_up    = dir_q ? above : ~below;
    assign step_floor = dir_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
    assign step_hit   = pending[step_floor] | floor_btn[step_floor];
    assign step_ahead = any_beyond(MAX_FLOORS'(pending), int'(step_floor), dir_q);
    assign clr_en     = (state_d == OPEN) || (state_q == OPEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OPEN;
            floor_q <= '0;
            dir_q   <= 1'b1;
            timer_q <= c_door_reload;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        case (state_q)
            OPEN: begin
                if (door_hold || floor_btn[floor_q]) begin
                    timer_d = c_door_reload;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else if (above || below) begin
                    state_d = MOVE;
                    dir_d   = pick_up;
                    timer_d = c_travel_reload;
                end else begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (here || floor_btn[floor_q]) begin
                    state_d = OPEN;
                    timer_d = c_door_reload;
                end else if (above || below) begin
                    // Zero timer: the first floor step happens on the next edge.
                    state_d = MOVE;
                    dir_d   = pick_up;
                    timer_d = '0;
                end
            end
            MOVE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else begin
                    floor_d = step_floor;
                    if (step_hit) begin
                        state_d = OPEN;
                        timer_d = c_door_reload;
                    end else if (step_ahead) begin
                        timer_d = c_travel_reload;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        door      = (state_q == OPEN);
        moving    = (state_q == MOVE);
        dir_up    = dir_q;
        floor_sel = floor_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_elev_ctrl_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_elev_ctrl_scan
//  Purpose  : Directed bench for two elev_ctrl_scan configurations vs a model.
//  Revision : 1.0
// ============================================================================
module tb_elev_ctrl_scan;

    localparam int M_IDLE = 0;
    localparam int M_OPEN = 1;
    localparam int M_MOVE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn4 = '0;
    logic       hold4 = 1'b0;
    logic [7:0] btn8 = '0;
    logic       hold8 = 1'b0;

    logic [1:0] floor4;
    logic       door4, moving4, dir4;
    logic [3:0] pend4;
    logic [2:0] floor8;
    logic       door8, moving8, dir8;
    logic [7:0] pend8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    elev_ctrl_scan #(.NUM_FLOORS(4), .DOOR_CYCLES(4), .TRAVEL_CYCLES(2)) u_dut4 (
        .clk(clk), .rst(rst), .floor_btn(btn4), .door_hold(hold4),
        .floor_sel(floor4), .door(door4), .moving(moving4), .dir_up(dir4),
        .pending(pend4)
    );

    elev_ctrl_scan #(.NUM_FLOORS(8), .DOOR_CYCLES(1), .TRAVEL_CYCLES(1)) u_dut8 (
        .clk(clk), .rst(rst), .floor_btn(btn8), .door_hold(hold8),
        .floor_sel(floor8), .door(door8), .moving(moving8), .dir_up(dir8),
        .pending(pend8)
    );

    // ---------------- behavioural model (index 0: 4 floors, 1: 8 floors) ----
    int       m_floor [2];
    int       m_left  [2];
    int       m_mode  [2];
    bit       m_dir   [2];
    bit [7:0] m_pend  [2];

    function automatic int door_len(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int travel_len(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic bit req_beyond(input bit [7:0] p, input int f, input bit up);
        for (int i = 0; i < 8; i++) begin
            if (p[i] && ((up && i > f) || (!up && i < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset(input int k);
        m_mode[k]  = M_OPEN;
        m_floor[k] = 0;
        m_dir[k]   = 1'b1;
        m_pend[k]  = '0;
        m_left[k]  = door_len(k) - 1;
    endtask

    task automatic model_step(input int k, input bit [7:0] btn, input bit hold);
        bit [7:0] p;
        int       f;
        int       mode_n;
        bit       any_req;
        p       = m_pend[k];
        f       = m_floor[k];
        mode_n  = m_mode[k];
        any_req = req_beyond(p, f, 1'b1) || req_beyond(p, f, 1'b0);
        case (m_mode[k])
            M_OPEN: begin
                if (hold || btn[f]) m_left[k] = door_len(k) - 1;
                else if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
                else if (any_req) begin
                    if (!req_beyond(p, f, m_dir[k])) m_dir[k] = !m_dir[k];
                    mode_n    = M_MOVE;
                    m_left[k] = travel_len(k) - 1;
                end else mode_n = M_IDLE;
            end
            M_IDLE: begin
                if (p[f] || btn[f]) begin
                    mode_n    = M_OPEN;
                    m_left[k] = door_len(k) - 1;
                end else if (any_req) begin
                    if (!req_beyond(p, f, m_dir[k])) m_dir[k] = !m_dir[k];
                    mode_n    = M_MOVE;
                    m_left[k] = 0;
                end
            end
            default: begin
                if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
                else begin
                    f = m_dir[k] ? f + 1 : f - 1;
                    if (p[f] || btn[f]) begin
                        mode_n    = M_OPEN;
                        m_left[k] = door_len(k) - 1;
                    end else if (req_beyond(p, f, m_dir[k])) m_left[k] = travel_len(k) - 1;
                    else mode_n = M_IDLE;
                end
            end
        endcase
        p = p | btn;
        if (mode_n == M_OPEN || m_mode[k] == M_OPEN) p[f] = 1'b0;
        m_pend[k]  = p;
        m_floor[k] = f;
        m_mode[k]  = mode_n;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, {4'b0000, btn4}, hold4);
            model_step(1, btn8, hold8);
        end
    end

    // ---------------- checking ----------------------------------------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("floor4",  int'(floor4),  m_floor[0]);
        chk("door4",   int'(door4),   int'(m_mode[0] == M_OPEN));
        chk("moving4", int'(moving4), int'(m_mode[0] == M_MOVE));
        chk("dir4",    int'(dir4),    int'(m_dir[0]));
        chk("pend4",   int'(pend4),   int'(m_pend[0][3:0]));
        chk("excl4",   int'(door4 & moving4), 0);
        chk("floor8",  int'(floor8),  m_floor[1]);
        chk("door8",   int'(door8),   int'(m_mode[1] == M_OPEN));
        chk("moving8", int'(moving8), int'(m_mode[1] == M_MOVE));
        chk("dir8",    int'(dir8),    int'(m_dir[1]));
        chk("pend8",   int'(pend8),   int'(m_pend[1]));
        chk("excl8",   int'(door8 & moving8), 0);
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic cyc(input logic [3:0] b4, input logic h4,
                       input logic [7:0] b8, input logic h8);
        btn4 = b4; hold4 = h4; btn8 = b8; hold8 = h8;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(4'b0000, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait4(input string name, input bit sel_moving,
                         input logic val, input int budget);
        int n;
        n = 0;
        while (((sel_moving ? moving4 : door4) !== val) && n < budget) begin
            idle(1);
            n++;
        end
        chk(name, int'(sel_moving ? moving4 : door4), int'(val));
    endtask

    task automatic await4(input int exp_floor, input int exp_dir, input int budget);
        wait4("wait_close4", 1'b0, 1'b0, budget);
        wait4("wait_open4",  1'b0, 1'b1, budget);
        chk("stop_floor4", int'(floor4), exp_floor);
        chk("stop_dir4",   int'(dir4),   exp_dir);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_floor", int'(floor4), 0);
        chk("rst_door",  int'(door4),  1);
        chk("rst_move",  int'(moving4), 0);
        chk("rst_dir",   int'(dir4),   1);
        chk("rst_pend",  int'(pend4),  0);
        rst = 1'b0;

        // Door dwell after reset
        idle(3); chk("dwell_open", int'(door4), 1);
        idle(1); chk("dwell_close", int'(door4), 0);

        // Single trip 0 -> 3
        cyc(4'b1000, 1'b0, 8'h00, 1'b0);
        chk("trip_pend", int'(pend4), 8);
        chk("trip_wait", int'(moving4), 0);
        idle(1); chk("trip_move", int'(moving4), 1); chk("trip_f0", int'(floor4), 0);
        idle(1); chk("trip_f1", int'(floor4), 1);
        idle(2); chk("trip_f2", int'(floor4), 2);
        idle(2); chk("trip_f3", int'(floor4), 3);
        chk("trip_door", int'(door4), 1); chk("trip_clr", int'(pend4), 0);
        idle(3); chk("trip_dwell", int'(door4), 1);
        idle(1); chk("trip_close", int'(door4), 0);

        // SCAN ordering
        cyc(4'b0001, 1'b0, 8'h00, 1'b0);
        await4(0, 0, 20);
        wait4("scan_close0", 1'b0, 1'b0, 20);
        cyc(4'b0010, 1'b0, 8'h00, 1'b0);
        await4(1, 1, 20);
        cyc(4'b1001, 1'b0, 8'h00, 1'b0);
        wait4("scan_depart", 1'b1, 1'b1, 20);
        cyc(4'b0100, 1'b0, 8'h00, 1'b0);
        chk("scan_pend", int'(pend4), 4'b1101);
        await4(2, 1, 20);
        await4(3, 1, 20);
        await4(0, 0, 30);

        // Door hold and re-trigger at floor 0
        wait4("hold_close", 1'b0, 1'b0, 20);
        cyc(4'b0001, 1'b0, 8'h00, 1'b0);
        chk("reopen", int'(door4), 1); chk("reopen_pend", int'(pend4), 0);
        repeat (10) cyc(4'b0000, 1'b1, 8'h00, 1'b0);
        chk("hold_open", int'(door4), 1);
        idle(3); chk("hold_tail", int'(door4), 1);
        idle(1); chk("hold_close2", int'(door4), 0);
        cyc(4'b0001, 1'b0, 8'h00, 1'b0);
        idle(2);
        cyc(4'b0001, 1'b0, 8'h00, 1'b0);
        chk("retrig_pend", int'(pend4), 0);
        idle(3); chk("retrig_open", int'(door4), 1);
        idle(1); chk("retrig_close", int'(door4), 0);

        // Asynchronous reset between floors 1 and 2
        cyc(4'b0100, 1'b0, 8'h00, 1'b0);
        idle(1); chk("mid_move", int'(moving4), 1);
        idle(1); chk("mid_f1", int'(floor4), 1); chk("mid_mv", int'(moving4), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_floor", int'(floor4), 0);
        chk("arst_door",  int'(door4),  1);
        chk("arst_move",  int'(moving4), 0);
        chk("arst_pend",  int'(pend4),  0);
        chk("arst_dir",   int'(dir4),   1);
        @(posedge clk);
        #2 rst = 1'b0;

        // Eight floors, single-cycle timers
        idle(2); chk("f8_idle", int'(door8), 0);
        cyc(4'b0000, 1'b0, 8'h80, 1'b0);
        chk("f8_pend", int'(pend8), 128);
        idle(1); chk("f8_move", int'(moving8), 1); chk("f8_f0", int'(floor8), 0);
        idle(6); chk("f8_f6", int'(floor8), 6); chk("f8_mv6", int'(moving8), 1);
        idle(1); chk("f8_f7", int'(floor8), 7); chk("f8_door", int'(door8), 1);
        idle(1); chk("f8_close", int'(door8), 0);
        cyc(4'b0000, 1'b0, 8'h01, 1'b0);
        idle(1); chk("f8_back", int'(moving8), 1);
        idle(7); chk("f8_bot", int'(floor8), 0); chk("f8_bdoor", int'(door8), 1);
        chk("f8_bdir", int'(dir8), 0);

        // Simultaneous up/down requests with dir_up=1: up first
        cyc(4'b0010, 1'b0, 8'h00, 1'b0);
        await4(1, 1, 20);
        wait4("sim_close", 1'b0, 1'b0, 20);
        cyc(4'b1001, 1'b0, 8'h00, 1'b0);
        chk("sim_pend", int'(pend4), 4'b1001);
        await4(3, 1, 20);
        await4(0, 0, 30);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
